ffq_buzzer_arbiter: RTL and testbench

Parametrised, clocked fastest-finger-first arbiter for NUM_PLAYERS active-low buzzer buttons.
- Synchronises and edge-detects each button.
- Arms on a host command and locks the first valid press, with a lowest-index tie-break.
- Handles a round timeout and drives a 7-segment digit plus a buzzer pulse.
- Sits between the raw player buttons and the host panel and display.

---
 rtl/ffq_buzzer_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ffq_buzzer_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ffq_buzzer_arbiter.sv
// Fastest-finger-first arbiter: synchronises active-low buzzers, locks the first press after arm.
// Optional macro FFQ_FALSE_START_EN adds per-player false-start flags and a false_start output.
module ffq_buzzer_arbiter #(
    parameter int NUM_PLAYERS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BEEP_CYCLES    = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   clear,
    input  logic [NUM_PLAYERS-1:0] buzz_n,
    output logic                   winner_valid,
    output logic [3:0]             winner_id,
    output logic                   timed_out,
    output logic                   beep,
    output logic [6:0]             seg,
    output logic [1:0]             state_o
`ifdef FFQ_FALSE_START_EN
    ,
    output logic [NUM_PLAYERS-1:0] false_start
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);
    localparam logic [6:0]    SEG_DASH  = 7'b0000001;
    localparam logic [6:0]    SEG_E     = 7'b1001111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_LOCKED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t                                   state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_PLAYERS-1:0]  sync_q, sync_d;
    logic [NUM_PLAYERS-1:0]                   hist_q, hist_d;
    logic [NUM_PLAYERS-1:0]                   press, elig;
    logic [3:0]                               first_id;
    logic [TW-1:0]                            tmo_cnt_q, tmo_cnt_d;
    logic [BW-1:0]                            beep_cnt_q, beep_cnt_d;
    logic [3:0]                               winner_id_q, winner_id_d;
    logic                                     winner_valid_q, winner_valid_d;
    logic                                     timed_out_q, timed_out_d;
    logic                                     beep_q, beep_d;
    logic [6:0]                               seg_q, seg_d;
    logic                                     lock;
    logic [NUM_PLAYERS-1:0]                   fs_q, fs_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    // A press is a released-to-pressed transition on the synchronised level, so a held button never re-triggers.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], buzz_n};
        hist_d = sync_q[SYNC_STAGES-1];
        press  = hist_q & ~sync_q[SYNC_STAGES-1];
    end

`ifdef FFQ_FALSE_START_EN
    always_comb begin
        fs_d = fs_q;
        if (clear)
            fs_d = '0;
        else if (state_q == S_IDLE)
            fs_d = fs_q | press;
        elig = press & ~fs_q;
    end
    assign false_start = fs_q;
`else
    always_comb begin
        fs_d = '0;
        elig = press;
    end
`endif

    always_comb begin
        first_id = 4'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (elig[i]) first_id = 4'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm) state_d = S_ARMED;
            S_ARMED: begin
                if (|elig)
                    state_d = S_LOCKED;
                else if ((TIMEOUT_CYCLES > 0) && (tmo_cnt_q == TMO_LAST))
                    state_d = S_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // Outputs are computed from the next state and registered, keeping inputs off any output path.
    always_comb begin
        lock        = (state_q == S_ARMED) && (state_d == S_LOCKED);
        winner_id_d = winner_id_q;
        tmo_cnt_d   = tmo_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        if (state_q == S_ARMED) tmo_cnt_d = tmo_cnt_q + 1'b1;
        else                    tmo_cnt_d = '0;
        if (lock) winner_id_d = first_id;
        if (state_d == S_IDLE) winner_id_d = 4'd0;
        if (lock)
            beep_cnt_d = BEEP_LOAD;
        else if (state_d == S_IDLE)
            beep_cnt_d = '0;
        else if (beep_cnt_q != '0)
            beep_cnt_d = beep_cnt_q - 1'b1;
        winner_valid_d = (state_d == S_LOCKED);
        timed_out_d    = (state_d == S_TIMEOUT);
        beep_d         = (beep_cnt_d != '0);
        case (state_d)
            S_LOCKED:  seg_d = seg_decode(winner_id_d);
            S_TIMEOUT: seg_d = SEG_E;
            default:   seg_d = SEG_DASH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '1;
            hist_q         <= '1;
            fs_q           <= '0;
            tmo_cnt_q      <= '0;
            beep_cnt_q     <= '0;
            winner_id_q    <= 4'd0;
            winner_valid_q <= 1'b0;
            timed_out_q    <= 1'b0;
            beep_q         <= 1'b0;
            seg_q          <= SEG_DASH;
        end else begin
            sync_q         <= sync_d;
            hist_q         <= hist_d;
            fs_q           <= fs_d;
            tmo_cnt_q      <= tmo_cnt_d;
            beep_cnt_q     <= beep_cnt_d;
            winner_id_q    <= winner_id_d;
            winner_valid_q <= winner_valid_d;
            timed_out_q    <= timed_out_d;
            beep_q         <= beep_d;
            seg_q          <= seg_d;
        end
    end

    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign timed_out    = timed_out_q;
    assign beep         = beep_q;
    assign seg          = seg_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ffq_buzzer_arbiter.sv
// Directed bench for ffq_buzzer_arbiter with 4 players, 2 sync stages, 20-cycle timeout, 5-cycle beep.
module tb_ffq_buzzer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] buzz_n = 4'hF;
    logic       winner_valid;
    logic [3:0] winner_id;
    logic       timed_out;
    logic       beep;
    logic [6:0] seg;
    logic [1:0] state_o;
`ifdef FFQ_FALSE_START_EN
    logic [3:0] false_start;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ffq_buzzer_arbiter #(
        .NUM_PLAYERS(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(20), .BEEP_CYCLES(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .buzz_n(buzz_n),
        .winner_valid(winner_valid), .winner_id(winner_id), .timed_out(timed_out),
        .beep(beep), .seg(seg), .state_o(state_o)
`ifdef FFQ_FALSE_START_EN
        , .false_start(false_start)
`endif
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_valid"}, 32'(winner_valid), 32'd0);
        check({tag, "_id"}, 32'(winner_id), 32'd0);
        check({tag, "_tmo"}, 32'(timed_out), 32'd0);
        check({tag, "_beep"}, 32'(beep), 32'd0);
        check({tag, "_seg"}, 32'(seg), 32'b0000001);
    endtask

    initial begin
        // reset
        #2 rst_n = 1'b0;
        step(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(1);

        // 1: single press, latency, digit and beep length
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        check("t1_armed", 32'(state_o), 32'd1);
        check("t1_seg_dash", 32'(seg), 32'b0000001);
        buzz_n[2] = 1'b0;
        step(2);
        check("t1_not_yet", 32'(winner_valid), 32'd0);
        step(1);
        check("t1_valid", 32'(winner_valid), 32'd1);
        check("t1_id", 32'(winner_id), 32'd3);
        check("t1_seg", 32'(seg), 32'b1111001);
        check("t1_state", 32'(state_o), 32'd2);
        check("t1_beep0", 32'(beep), 32'd1);
        for (int i = 1; i < 5; i++) begin
            step(1);
            check("t1_beep_hi", 32'(beep), 32'd1);
        end
        step(1);
        check("t1_beep_lo", 32'(beep), 32'd0);
        buzz_n = 4'hF;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_reset_outputs("t1_clear");

        // 2: tie-break and later press ignored
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        buzz_n = 4'b0101;
        step(3);
        check("t2_id", 32'(winner_id), 32'd2);
        check("t2_seg", 32'(seg), 32'b1101101);
        buzz_n[0] = 1'b0;
        arm = 1'b1;
        step(4);
        arm = 1'b0;
        check("t2_id_hold", 32'(winner_id), 32'd2);
        check("t2_state_hold", 32'(state_o), 32'd2);
        buzz_n = 4'hF;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t2_clear_state", 32'(state_o), 32'd0);

        // 3: timeout after exactly 20 armed clocks
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(19);
        check("t3_still_armed", 32'(state_o), 32'd1);
        check("t3_no_tmo", 32'(timed_out), 32'd0);
        step(1);
        check("t3_state", 32'(state_o), 32'd3);
        check("t3_tmo", 32'(timed_out), 32'd1);
        check("t3_seg", 32'(seg), 32'b1001111);
        check("t3_valid", 32'(winner_valid), 32'd0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t3_clr_state", 32'(state_o), 32'd0);
        check("t3_clr_seg", 32'(seg), 32'b0000001);
        check("t3_clr_tmo", 32'(timed_out), 32'd0);

        // 4: button held across arm does not count
        buzz_n[0] = 1'b0;
        step(3);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(5);
        check("t4_held_state", 32'(state_o), 32'd1);
        check("t4_held_valid", 32'(winner_valid), 32'd0);
        buzz_n[0] = 1'b1;
        step(3);
        buzz_n[0] = 1'b0;
        step(3);
        check("t4_id", 32'(winner_id), 32'd1);
        check("t4_seg", 32'(seg), 32'b0110000);
        buzz_n = 4'hF;
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // 5: clear beats arm while locked, beep truncated; async reset mid-round
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        buzz_n[3] = 1'b0;
        step(3);
        check("t5_id", 32'(winner_id), 32'd4);
        check("t5_seg", 32'(seg), 32'b0110011);
        clear = 1'b1;
        arm = 1'b1;
        step(1);
        clear = 1'b0;
        arm = 1'b0;
        check_reset_outputs("t5_clear_arm");
        buzz_n = 4'hF;
        step(1);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(2);
        check("t5_armed", 32'(state_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async_rst");
        step(1);
        rst_n = 1'b1;
        step(1);

`ifdef FFQ_FALSE_START_EN
        // 6: false start in IDLE blocks player 2 for the round
        buzz_n[1] = 1'b0;
        step(3);
        buzz_n[1] = 1'b1;
        step(2);
        check("t6_fs_idle", 32'(false_start), 32'b0010);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        check("t6_fs_arm", 32'(false_start), 32'b0010);
        buzz_n[1] = 1'b0;
        step(3);
        check("t6_p2_ignored", 32'(state_o), 32'd1);
        buzz_n[3] = 1'b0;
        step(3);
        check("t6_id", 32'(winner_id), 32'd4);
        check("t6_fs_lock", 32'(false_start), 32'b0010);
        buzz_n = 4'hF;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t6_fs_clear", 32'(false_start), 32'b0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
